// File: rtl/ov5640_pkg.sv
// ov5640_pkg
// Shared definitions for the OV5640 DVP receiver.
//   state_t : capture FSM states
//   PIX_W   : width of one RGB565 output pixel
package ov5640_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        WAIT_VE = 2'd2,
        ACTIVE  = 2'd3
    } state_t;

    localparam int PIX_W = 16;

endpackage

// File: rtl/ov5640_dvp_rx_cdc_sync_2ff.sv
// cdc_sync_2ff
// Plain two-flop synchronizer for a bundle of asynchronous bits. No reset:
// the flops settle to the input within two clocks.
// Ports:
//   i_clk : destination clock
//   i_d   : asynchronous input bits
//   o_q   : synchronized output bits
module cdc_sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        r_meta <= i_d;
        r_sync <= r_meta;
    end

    assign o_q = r_sync;

endmodule

// File: rtl/ov5640_dvp_rx.sv
// ov5640_dvp_rx
// Captures OV5640 DVP video (PCLK treated as data) in the system clock domain
// and emits RGB565 pixels as a one-entry valid/ready stream.
// Ports:
//   clk, rst        : system clock, synchronous active-high reset
//   cam_ready       : camera out of reset/power-down (level)
//   cam_pclk/vsync/href/data : raw DVP signals
//   m_tdata/tvalid/tready/tuser/tlast : pixel stream (tuser = first pixel of
//                     frame, tlast = last pixel of line)
//   overflow        : sticky, a pixel was dropped while the output was stalled
//   size_err        : sticky, a line or frame had the wrong size
// Handshake: a beat transfers on a clk edge where m_tvalid && m_tready; while
// m_tvalid && !m_tready the payload holds and m_tvalid stays high.
module ov5640_dvp_rx
    import ov5640_pkg::*;
#(
    parameter int H_ACTIVE       = 640,
    parameter int V_ACTIVE       = 480,
    parameter bit VS_ACTIVE_HIGH = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cam_ready,
    input  logic             cam_pclk,
    input  logic             cam_vsync,
    input  logic             cam_href,
    input  logic [7:0]       cam_data,
    output logic [PIX_W-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tuser,
    output logic             m_tlast,
    output logic             overflow,
    output logic             size_err
);

    localparam int PC_W = $clog2(H_ACTIVE + 1);
    localparam int LC_W = $clog2(V_ACTIVE + 1);
    localparam logic [PC_W-1:0] PC_MAX = '1;
    localparam logic [PC_W-1:0] H_LAST = PC_W'(H_ACTIVE - 1);
    localparam logic [PC_W-1:0] H_FULL = PC_W'(H_ACTIVE);
    localparam logic [LC_W-1:0] LC_MAX = '1;
    localparam logic [LC_W-1:0] V_FULL = LC_W'(V_ACTIVE);

    // All camera bits go through the same synchronizer so that vsync, href
    // and data are aligned with the pclk edge that samples them.
    logic [10:0] w_cam_sync;

    cdc_sync_2ff #(.WIDTH(11)) u_sync (
        .i_clk (clk),
        .i_d   ({cam_pclk, cam_vsync, cam_href, cam_data}),
        .o_q   (w_cam_sync)
    );

    logic       w_pclk, w_vsync, w_href, w_vs_act;
    logic [7:0] w_data;
    assign w_pclk   = w_cam_sync[10];
    assign w_vsync  = w_cam_sync[9];
    assign w_href   = w_cam_sync[8];
    assign w_data   = w_cam_sync[7:0];
    assign w_vs_act = w_vsync ^ ~VS_ACTIVE_HIGH;

    logic            r_pclk_d;
    logic            r_href_d;    // href as seen on the previous pclk_rise
    state_t          r_state, w_state_nxt;
    logic            r_byte_ph;
    logic [7:0]      r_hi_byte;
    logic            r_first_px;
    logic [PC_W-1:0] r_pix_cnt;
    logic [LC_W-1:0] r_line_cnt;

    logic w_pclk_rise;
    assign w_pclk_rise = w_pclk & ~r_pclk_d;

    // Next-state logic; losing cam_ready overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        if (!cam_ready) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = WAIT_VS;
                WAIT_VS: if (w_pclk_rise && w_vs_act)  w_state_nxt = WAIT_VE;
                WAIT_VE: if (w_pclk_rise && !w_vs_act) w_state_nxt = ACTIVE;
                ACTIVE:  if (w_pclk_rise && w_vs_act)  w_state_nxt = WAIT_VE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    logic            w_active, w_enter_active, w_px_done, w_line_end, w_frame_end;
    logic [LC_W-1:0] w_line_inc, w_line_chk;
    logic [PIX_W-1:0] w_pixel;
    logic            w_load;

    always_comb begin
        w_active       = (r_state == ACTIVE) && cam_ready;
        w_enter_active = (r_state == WAIT_VE) && (w_state_nxt == ACTIVE);
        w_px_done      = w_active && w_pclk_rise && w_href && r_byte_ph;
        w_line_end     = w_active && w_pclk_rise && r_href_d && !w_href;
        w_frame_end    = w_active && w_pclk_rise && w_vs_act;
        w_line_inc     = (r_line_cnt == LC_MAX) ? r_line_cnt : r_line_cnt + 1'b1;
        // A line ending on the same pclk_rise as the frame is counted first.
        w_line_chk     = w_line_end ? w_line_inc : r_line_cnt;
        w_pixel        = {r_hi_byte, w_data};
        w_load         = w_px_done && (!m_tvalid || m_tready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pclk_d   <= 1'b0;
            r_href_d   <= 1'b0;
            r_byte_ph  <= 1'b0;
            r_hi_byte  <= '0;
            r_first_px <= 1'b0;
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
            m_tdata    <= '0;
            m_tvalid   <= 1'b0;
            m_tuser    <= 1'b0;
            m_tlast    <= 1'b0;
            overflow   <= 1'b0;
            size_err   <= 1'b0;
        end else begin
            r_pclk_d <= w_pclk;
            if (w_pclk_rise) r_href_d <= w_href;

            if (!w_active) begin
                // Outside capture any half pixel is discarded.
                r_byte_ph <= 1'b0;
            end else if (w_pclk_rise && w_href) begin
                r_byte_ph <= ~r_byte_ph;
                if (!r_byte_ph) r_hi_byte <= w_data;
            end

            if (w_enter_active) begin
                r_pix_cnt  <= '0;
                r_line_cnt <= '0;
                r_first_px <= 1'b1;
            end

            if (w_px_done && r_pix_cnt != PC_MAX) r_pix_cnt <= r_pix_cnt + 1'b1;

            if (w_line_end) begin
                r_line_cnt <= w_line_inc;
                r_pix_cnt  <= '0;
                r_byte_ph  <= 1'b0;
                if (r_pix_cnt != H_FULL) size_err <= 1'b1;
            end

            if (w_frame_end && w_line_chk != V_FULL) size_err <= 1'b1;

            if (w_load) begin
                m_tdata    <= w_pixel;
                m_tvalid   <= 1'b1;
                m_tuser    <= r_first_px;
                m_tlast    <= (r_pix_cnt == H_LAST);
                r_first_px <= 1'b0;
            end else begin
                if (w_px_done) overflow <= 1'b1;
                if (m_tvalid && m_tready) m_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ov5640_dvp_rx.sv
module tb_ov5640_dvp_rx;
  import ov5640_pkg::*;

  localparam int H = 4;
  localparam int V = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             cam_ready;
  logic             cam_pclk;
  logic             cam_vsync;
  logic             cam_href;
  logic [7:0]       cam_data;
  logic [PIX_W-1:0] m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic             m_tuser;
  logic             m_tlast;
  logic             overflow;
  logic             size_err;

  ov5640_dvp_rx #(.H_ACTIVE(H), .V_ACTIVE(V), .VS_ACTIVE_HIGH(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .cam_ready (cam_ready),
    .cam_pclk  (cam_pclk),
    .cam_vsync (cam_vsync),
    .cam_href  (cam_href),
    .cam_data  (cam_data),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tuser   (m_tuser),
    .m_tlast   (m_tlast),
    .overflow  (overflow),
    .size_err  (size_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [17:0] exp_q[$];   // {tuser, tlast, tdata}
  bit          model_first = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One pclk period = 4 clk; bus changes with the falling pclk edge.
  task automatic cam_cycle(input logic vs, input logic hr, input logic [7:0] d);
    cam_pclk  = 1'b0;
    cam_vsync = vs;
    cam_href  = hr;
    cam_data  = d;
    repeat (2) tick();
    cam_pclk = 1'b1;
    repeat (2) tick();
  endtask

  task automatic send_vsync(input bit arm);
    repeat (3) cam_cycle(1'b1, 1'b0, 8'h00);
    repeat (2) cam_cycle(1'b0, 1'b0, 8'h00);
    if (arm) model_first = 1'b1;
  endtask

  // Sends nbytes of incrementing data; only the first 'keep' pixels of the
  // line are expected at the output.
  task automatic send_line(input logic [7:0] start, input int nbytes, input int keep);
    logic [7:0] hi;
    logic [7:0] b;
    hi = 8'h00;
    for (int i = 0; i < nbytes; i++) begin
      b = start + 8'(i);
      if (i % 2 == 0) begin
        hi = b;
      end else begin
        int k;
        k = i / 2;
        if (k < keep) begin
          exp_q.push_back({model_first, (k == H - 1), hi, b});
          model_first = 1'b0;
        end
      end
      cam_cycle(1'b0, 1'b1, b);
    end
    repeat (2) cam_cycle(1'b0, 1'b0, 8'h00);
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    while ((exp_q.size() != 0 || m_tvalid) && cnt < 200) begin
      tick();
      cnt++;
    end
    check("drain_remaining", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tdata"}, 32'(m_tdata), 32'd0);
    check({tag, "_ctrl"}, 32'({m_tvalid, m_tuser, m_tlast}), 32'd0);
    check({tag, "_flags"}, 32'({overflow, size_err}), 32'd0);
  endtask

  // ---------------- output monitor ----------------
  logic [17:0] held;
  bit          holding = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      holding = 1'b0;
    end else begin
      if (holding) begin
        check("stall_tvalid", 32'(m_tvalid), 32'd1);
        check("stall_payload", 32'({m_tuser, m_tlast, m_tdata}), 32'(held));
      end
      if (m_tvalid && m_tready) begin
        n_vec++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_beat: observed 0x%0h with no pixel expected",
                 {m_tuser, m_tlast, m_tdata});
        end
        if (exp_q.size() != 0) begin
          logic [17:0] e;
          e = exp_q.pop_front();
          check("beat", 32'({m_tuser, m_tlast, m_tdata}), 32'(e));
        end
      end
      holding = m_tvalid && !m_tready;
      held    = {m_tuser, m_tlast, m_tdata};
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst       = 1'b1;
    cam_ready = 1'b0;
    cam_pclk  = 1'b0;
    cam_vsync = 1'b0;
    cam_href  = 1'b0;
    cam_data  = 8'h00;
    m_tready  = 1'b1;
    repeat (4) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Nominal frame
    cam_ready = 1'b1;
    tick();
    send_vsync(1'b1);
    send_line(8'h00, 8, 99);
    send_line(8'h08, 8, 99);
    send_vsync(1'b1);
    drain();
    check("nominal_flags", 32'({overflow, size_err}), 32'd0);

    // Late start: camera ready rises mid-frame
    cam_ready = 1'b0;
    tick();
    send_line(8'h20, 8, 0);
    send_vsync(1'b0);
    send_line(8'h30, 8, 0);
    cam_ready = 1'b1;
    send_line(8'h40, 8, 0);
    send_vsync(1'b1);
    send_line(8'h50, 8, 99);
    send_line(8'h58, 8, 99);
    send_vsync(1'b1);
    drain();
    check("late_flags", 32'({overflow, size_err}), 32'd0);

    // Backpressure across a full line
    m_tready = 1'b0;
    send_line(8'h60, 8, 1);
    check("bp_overflow", 32'(overflow), 32'd1);
    check("bp_tvalid", 32'(m_tvalid), 32'd1);
    check("bp_tdata", 32'(m_tdata), 32'h6061);
    m_tready = 1'b1;
    drain();
    send_line(8'h70, 8, 99);
    send_vsync(1'b1);
    drain();
    check("bp_size_err", 32'(size_err), 32'd0);

    // Odd byte count: ninth byte discarded, next line starts on high byte
    send_line(8'h80, 9, 99);
    send_line(8'h90, 8, 99);
    send_vsync(1'b1);
    drain();
    check("odd_size_err", 32'(size_err), 32'd0);

    // Short line
    send_line(8'hA0, 6, 99);
    check("short_size_err", 32'(size_err), 32'd1);
    send_line(8'hB0, 8, 99);
    send_vsync(1'b1);
    drain();

    // Reset mid-line after three bytes
    cam_cycle(1'b0, 1'b1, 8'hD0);
    exp_q.push_back({model_first, 1'b0, 16'hD0D1});
    model_first = 1'b0;
    cam_cycle(1'b0, 1'b1, 8'hD1);
    cam_cycle(1'b0, 1'b1, 8'hD2);
    drain();
    rst = 1'b1;
    tick();
    check_reset_outputs("midline_reset");
    rst = 1'b0;
    cam_cycle(1'b0, 1'b1, 8'hD3);
    repeat (2) cam_cycle(1'b0, 1'b0, 8'h00);
    send_vsync(1'b1);
    send_line(8'hC0, 8, 99);
    send_line(8'hC8, 8, 99);
    send_vsync(1'b1);
    drain();
    check("post_reset_flags", 32'({overflow, size_err}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
